usb_packet_framer: RTL
======================

# usb_packet_framer

Downstream stage of the acquisition controller, between the controller's 16-bit USB data stream (normal ACQ, sweep ACQ, S-curve or ADC data, already muxed) and the external USB FX FIFO. Buffers incoming words, wraps them into fixed-length packets with header, sequence number, XOR checksum and trailer, and throttles writes on the FX FIFO full flag. At end of run it pads and closes the last packet, then requests a short-packet commit.

## Interface
- PAYLOAD_WORDS, 256: payload words per packet (≥2)
- BUF_DEPTH, 512: internal buffer depth in words (power of 2, ≥ PAYLOAD_WORDS)
- HEADER_WORD, 16'hFA5A: first word of every packet
- TRAILER_WORD, 16'hFEEE: last word of every packet
- PAD_WORD, 16'h0000: filler for the final partial packet

Ports (one clock; reset is asynchronous and active-high):
- Clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears everything
- StartStop  in  1  run level (USB start/stop); rising edge starts a run, falling edge ends it
- DataIn  in  16  data word from the controller
- DataIn_en  in  1  DataIn valid, one word per cycle
- UsbDataFifoFull  in  1  FX FIFO programmable-full, at least 2 words margin
- UsbFifoData  out  16  word to the FX FIFO
- UsbFifoData_en  out  1  write strobe, one word per cycle
- PacketEnd  out  1  one-cycle pulse: commit short packet (drives nPKTEND logic)
- Overflow  out  1  sticky: a DataIn word was dropped this run
- PacketCount  out  16  packets completed this run

## Operation
- Buffer: synchronous FIFO, BUF_DEPTH×16. Written when DataIn_en && !buffer full && run active. If full, the word is dropped and Overflow is set. DataIn_en outside a run is ignored.
- Run control: StartStop rising edge, only in IDLE, clears Overflow, PacketCount, sequence counter and buffer. A rising edge outside IDLE is ignored.
- FSM states:
  - IDLE: wait for a run. In a run, go to HDR when buffer count ≥ PAYLOAD_WORDS, or on a pending stop with a nonempty buffer.
  - HDR: emit HEADER_WORD.
  - SEQ: emit the sequence number, then increment it (16-bit, wraps 0xFFFF→0x0000).
  - PAY: emit PAYLOAD_WORDS words from the buffer. Once a pending stop is latched and the buffer is empty, emit PAD_WORD for the remainder. Checksum is the XOR of all emitted payload words, pads included.
  - CKS: emit the checksum.
  - TRL: emit TRAILER_WORD and increment PacketCount. Next: IDLE, or FLUSH if stop is pending and the buffer is empty.
  - FLUSH: pulse PacketEnd, clear the pending stop, go to IDLE.
- Stop: a StartStop falling edge latches stop-pending.
  - Data arriving in the same cycle as the edge is still accepted.
  - Stop with an empty buffer in IDLE goes straight to FLUSH, so no empty packet is sent.
- Throttle: the FSM advances and emits a word only in cycles with UsbDataFifoFull low. Otherwise it holds state and the word.

## Timing
- Reset values: UsbFifoData=0, UsbFifoData_en=0, PacketEnd=0, Overflow=0, PacketCount=0, FSM=IDLE, buffer empty.
- All outputs are registered. A word chosen in cycle t appears with UsbFifoData_en in cycle t+1.
- UsbDataFifoFull is acted on one cycle late. At most 1 extra write lands after full rises, which the 2-word margin covers.
- Packet length is PAYLOAD_WORDS+4 words. With full low and the buffer primed, words are back-to-back with no bubbles.
- Buffer latency: a word written in cycle t can be emitted at t+2 at the earliest (first-word fall-through not required).
- PacketEnd is asserted in the cycle after the TRL word's strobe, never coincident with UsbFifoData_en.
- Reset mid-packet: the packet is abandoned with no trailer, and the host resyncs on HEADER_WORD.
- Simultaneous buffer read and write at full: the write is accepted; full is computed after the read.

## Structure
- Package usb_framer_pkg contains:
  - the state enum (IDLE, HDR, SEQ, PAY, CKS, TRL, FLUSH)
  - default HEADER/TRAILER/PAD constants
  - the packet overhead constant (4)
- One sub-module, framer_sync_fifo (parameterised depth/width, count output), instantiated once.

## Test plan
- PAYLOAD_WORDS=4; start; feed 8 words 0x0001..0x0008; stop:
  - expect FA5A, 0000, 1,2,3,4, 0004, FEEE
  - then FA5A, 0001, 5,6,7,8, 000C, FEEE
  - then PacketEnd pulse; PacketCount=2.
- PAYLOAD_WORDS=4; feed 0x0011, 0x0022; stop:
  - expect FA5A, 0000, 0011, 0022, 0000, 0000, 0033, FEEE
  - then PacketEnd.
- Hold UsbDataFifoFull high for 10 cycles mid-payload:
  - no more than 1 write after the rising edge
  - stream resumes with no lost or duplicated word.
- BUF_DEPTH=8 with full held high; feed 12 words:
  - 8 stored, Overflow=1
  - after release, the 8 words appear in order
  - next run start clears Overflow.
- Preload the sequence counter to near wrap by running 65537 packets (or force): sequence goes FFFF→0000.
- Assert reset mid-PAY:
  - all outputs 0 the same cycle
  - next run starts with sequence 0000 and an empty buffer.

Source files
------------

// File: rtl/usb_framer_pkg.sv
// Shared types and constants for the USB packet framer.
// Packets are HEADER, SEQ, payload, CHECKSUM, TRAILER.
package usb_framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEQ,
        PAY,
        CKS,
        TRL,
        FLUSH
    } state_e;

    localparam logic [15:0] DEF_HEADER_WORD  = 16'hFA5A;
    localparam logic [15:0] DEF_TRAILER_WORD = 16'hFEEE;
    localparam logic [15:0] DEF_PAD_WORD     = 16'h0000;
    localparam int          PKT_OVERHEAD     = 4;

endpackage

// File: rtl/framer_sync_fifo.sv
// Synchronous FIFO with unregistered read port and occupancy count.
// A write at full is accepted when a read happens in the same cycle.
module framer_sync_fifo #(
    parameter int DEPTH = 512,
    parameter int WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == FULL_CNT);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign rd_ok     = rd_en_i && !empty_o;
    assign wr_ok     = wr_en_i && (!full_o || rd_ok);

    always_ff @(posedge clk_i) begin
        if (wr_ok && !clr_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb_packet_framer.sv
// Wraps the controller word stream into fixed-length packets for the FX FIFO,
// throttled on the FIFO full flag, with pad-and-commit at end of run.
module usb_packet_framer
    import usb_framer_pkg::*;
#(
    parameter int          PAYLOAD_WORDS = 256,
    parameter int          BUF_DEPTH     = 512,
    parameter logic [15:0] HEADER_WORD   = DEF_HEADER_WORD,
    parameter logic [15:0] TRAILER_WORD  = DEF_TRAILER_WORD,
    parameter logic [15:0] PAD_WORD      = DEF_PAD_WORD
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        StartStop,
    input  logic [15:0] DataIn,
    input  logic        DataIn_en,
    input  logic        UsbDataFifoFull,
    output logic [15:0] UsbFifoData,
    output logic        UsbFifoData_en,
    output logic        PacketEnd,
    output logic        Overflow,
    output logic [15:0] PacketCount
);

    localparam int CW  = $clog2(BUF_DEPTH) + 1;
    localparam int PCW = $clog2(PAYLOAD_WORDS);
    localparam logic [CW-1:0]  PAY_THR  = CW'(PAYLOAD_WORDS);
    localparam logic [PCW-1:0] PAY_LAST = PCW'(PAYLOAD_WORDS - 1);

    state_e         state_q;
    logic           ss_q;
    logic           run_q;
    logic           stop_q;
    logic [15:0]    seq_q;
    logic [15:0]    cks_q;
    logic [PCW-1:0] pay_cnt_q;
    logic [15:0]    data_q;
    logic           en_q;
    logic           pkt_end_q;
    logic           ovf_q;
    logic [15:0]    pkt_cnt_q;

    logic           rise;
    logic           fall;
    logic           start;
    logic           adv;
    logic           buf_wr;
    logic           buf_rd;
    logic           buf_full;
    logic           buf_empty;
    logic [CW-1:0]  buf_count;
    logic [15:0]    buf_data;
    logic [15:0]    pay_word_d;

    assign rise   = StartStop && !ss_q;
    assign fall   = !StartStop && ss_q;
    assign start  = rise && (state_q == IDLE);
    assign adv    = !UsbDataFifoFull;
    assign buf_wr = DataIn_en && run_q;
    assign buf_rd = (state_q == PAY) && adv && !buf_empty;

    // Once the buffer runs dry in PAY, only a pending stop lets pads go out.
    assign pay_word_d = buf_empty ? PAD_WORD : buf_data;

    framer_sync_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (16)
    ) u_buf (
        .clk_i     (Clk),
        .rst_i     (reset),
        .clr_i     (start),
        .wr_en_i   (buf_wr),
        .wr_data_i (DataIn),
        .rd_en_i   (buf_rd),
        .rd_data_o (buf_data),
        .count_o   (buf_count),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ss_q      <= 1'b0;
            run_q     <= 1'b0;
            stop_q    <= 1'b0;
            seq_q     <= '0;
            cks_q     <= '0;
            pay_cnt_q <= '0;
            data_q    <= '0;
            en_q      <= 1'b0;
            pkt_end_q <= 1'b0;
            ovf_q     <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            ss_q      <= StartStop;
            en_q      <= 1'b0;
            pkt_end_q <= 1'b0;
            if (buf_wr && buf_full && !buf_rd) begin
                ovf_q <= 1'b1;
            end
            if (start) begin
                run_q     <= 1'b1;
                stop_q    <= 1'b0;
                ovf_q     <= 1'b0;
                pkt_cnt_q <= '0;
                seq_q     <= '0;
            end else if (fall && run_q) begin
                run_q  <= 1'b0;
                stop_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if ((run_q || stop_q) && buf_count >= PAY_THR) begin
                        state_q <= HDR;
                    end else if (stop_q) begin
                        state_q <= buf_empty ? FLUSH : HDR;
                    end
                end
                HDR: begin
                    if (adv) begin
                        data_q  <= HEADER_WORD;
                        en_q    <= 1'b1;
                        state_q <= SEQ;
                    end
                end
                SEQ: begin
                    if (adv) begin
                        data_q    <= seq_q;
                        en_q      <= 1'b1;
                        seq_q     <= seq_q + 16'd1;
                        cks_q     <= '0;
                        pay_cnt_q <= '0;
                        state_q   <= PAY;
                    end
                end
                PAY: begin
                    if (adv && (!buf_empty || stop_q)) begin
                        data_q    <= pay_word_d;
                        en_q      <= 1'b1;
                        cks_q     <= cks_q ^ pay_word_d;
                        pay_cnt_q <= pay_cnt_q + 1'b1;
                        if (pay_cnt_q == PAY_LAST) begin
                            state_q <= CKS;
                        end
                    end
                end
                CKS: begin
                    if (adv) begin
                        data_q  <= cks_q;
                        en_q    <= 1'b1;
                        state_q <= TRL;
                    end
                end
                TRL: begin
                    if (adv) begin
                        data_q    <= TRAILER_WORD;
                        en_q      <= 1'b1;
                        pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        state_q   <= (stop_q && buf_empty) ? FLUSH : IDLE;
                    end
                end
                FLUSH: begin
                    pkt_end_q <= 1'b1;
                    stop_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign UsbFifoData    = data_q;
    assign UsbFifoData_en = en_q;
    assign PacketEnd      = pkt_end_q;
    assign Overflow       = ovf_q;
    assign PacketCount    = pkt_cnt_q;

endmodule
